// File: rtl/icc_flag_unit_if.sv
// ============================================================================
// Module      : icc_flag_unit_if
// Description : Bus bundle between the pipeline and the icc flag unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icc_flag_unit_if;
  logic       stall;
  logic       flush;
  logic       EX_modify_cc;
  logic [3:0] EX_alu_flags;
  logic       EX_wr_psr;
  logic [3:0] EX_wr_psr_icc;
  logic [3:0] flags;
  logic [3:0] icc_q;
  logic       psr_busy;
  logic [1:0] fwd_src;

  modport master (
    output stall, flush, EX_modify_cc, EX_alu_flags, EX_wr_psr, EX_wr_psr_icc,
    input  flags, icc_q, psr_busy, fwd_src
  );

  modport slave (
    input  stall, flush, EX_modify_cc, EX_alu_flags, EX_wr_psr, EX_wr_psr_icc,
    output flags, icc_q, psr_busy, fwd_src
  );
endinterface

`default_nettype wire

// File: rtl/icc_flag_unit.sv
// ============================================================================
// Module      : icc_flag_unit
// Description : Condition-code producer: EX/MEM/WB cc tracking, committed icc,
//               delayed WRPSR icc writes and forwarded flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icc_flag_unit #(
  parameter int         WRPSR_DELAY = 3,
  parameter logic [3:0] ICC_RESET   = 4'b0000
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  icc_flag_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } wr_state_t;

  localparam logic [2:0] c_DELAY = 3'(WRPSR_DELAY);

  logic       r_mem_v;
  logic       r_wb_v;
  logic [3:0] r_mem_f;
  logic [3:0] r_wb_f;
  logic [3:0] r_icc_q;
  logic [3:0] r_wr_val;
  logic [2:0] r_wr_cnt;
  logic       r_psr_busy;
  wr_state_t  r_state;

  logic       w_ex_v;
  logic       w_accept;
  logic       w_commit;
  logic [3:0] w_flags;
  logic [1:0] w_fwd_src;

  assign w_ex_v   = bus.EX_modify_cc & ~bus.flush;
  assign w_accept = bus.EX_wr_psr & ~bus.flush & ~bus.stall;
  // A re-accepted WRPSR in the final pending cycle restarts instead of committing.
  assign w_commit = ~bus.stall & ~w_accept & (r_state == PEND) & (r_wr_cnt == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_v <= 1'b0;
      r_wb_v  <= 1'b0;
      r_mem_f <= 4'b0000;
      r_wb_f  <= 4'b0000;
      r_icc_q <= ICC_RESET;
    end else if (!bus.stall) begin
      r_mem_v <= w_ex_v;
      r_mem_f <= bus.EX_alu_flags;
      r_wb_v  <= r_mem_v & ~bus.flush;
      r_wb_f  <= r_mem_f;
      if (w_commit)
        r_icc_q <= r_wr_val;
      else if (r_wb_v)
        r_icc_q <= r_wb_f;
    end
  end

  // WRPSR delay machine; flush never cancels a write that is already pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_cnt   <= 3'd0;
      r_wr_val   <= 4'b0000;
      r_psr_busy <= 1'b0;
    end else if (!bus.stall) begin
      if (w_accept) begin
        r_state    <= PEND;
        r_wr_cnt   <= c_DELAY;
        r_wr_val   <= bus.EX_wr_psr_icc;
        r_psr_busy <= 1'b1;
      end else begin
        case (r_state)
          PEND: begin
            r_wr_cnt <= r_wr_cnt - 3'd1;
            if (r_wr_cnt == 3'd1) begin
              r_state    <= IDLE;
              r_psr_busy <= 1'b0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_wr_cnt <= 3'd0;
          end
        endcase
      end
    end
  end

  // Youngest in-flight cc producer wins.
  always_comb begin
    w_flags   = r_icc_q;
    w_fwd_src = 2'd0;
    if (w_ex_v) begin
      w_flags   = bus.EX_alu_flags;
      w_fwd_src = 2'd3;
    end else if (r_mem_v) begin
      w_flags   = r_mem_f;
      w_fwd_src = 2'd2;
    end else if (r_wb_v) begin
      w_flags   = r_wb_f;
      w_fwd_src = 2'd1;
    end
  end

  assign bus.flags    = w_flags;
  assign bus.fwd_src  = w_fwd_src;
  assign bus.icc_q    = r_icc_q;
  assign bus.psr_busy = r_psr_busy;

endmodule

`default_nettype wire

// File: tb/tb_icc_flag_unit.sv
// ============================================================================
// Module      : tb_icc_flag_unit
// Description : Directed self-checking bench for icc_flag_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icc_flag_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  icc_flag_unit_if bus ();

  icc_flag_unit #(
    .WRPSR_DELAY (3),
    .ICC_RESET   (4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: inputs for a cycle, then outputs expected during that cycle.
  typedef struct packed {
    logic       mcc;
    logic [3:0] alu;
    logic       wr;
    logic [3:0] wicc;
    logic       st;
    logic       fl;
    logic [3:0] ef;
    logic [3:0] ei;
    logic       eb;
    logic [1:0] es;
  } step_t;

  task automatic drive(input step_t s);
    bus.EX_modify_cc  = s.mcc;
    bus.EX_alu_flags  = s.alu;
    bus.EX_wr_psr     = s.wr;
    bus.EX_wr_psr_icc = s.wicc;
    bus.stall         = s.st;
    bus.flush         = s.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.EX_modify_cc = 1'b0; bus.EX_alu_flags = 4'b0000;
    bus.EX_wr_psr = 1'b0; bus.EX_wr_psr_icc = 4'b0000;
    bus.stall = 1'b0; bus.flush = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== 11'b0000_0000_0_00) begin
      errors++;
      $display("FAIL reset: flags/icc/busy/src got %b/%b/%b/%0d expected 0000/0000/0/0",
               bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src);
    end
    #12 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    step_t v [4] = '{
      '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd3},
      '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2},
      '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd1},
      '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL single step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    step_t v [5] = '{
      '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0100, 1'b0, 2'd3},
      '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0100, 1'b0, 2'd3},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0100, 1'b0, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1000, 1'b0, 2'd1},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL back_to_back step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    step_t v [10] = '{
      '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b0, 2'd3},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b0, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b0, 2'd1},
      '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0},
      '{1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0010, 1'b0, 2'd3},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0111, 4'b0010, 1'b0, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL flush step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_wrpsr_override();
    step_t v [6] = '{
      '{1'b0, 4'b0000, 1'b1, 4'b1010, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0},
      '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0010, 1'b1, 2'd3},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0010, 1'b1, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0010, 1'b1, 2'd1},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b0, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL wrpsr_override step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    step_t v [7] = '{
      '{1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b0, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1010, 4'b1010, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b1010, 4'b1010, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL stall step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_stall_flush_pipe();
    step_t v [6] = '{
      '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0110, 1'b0, 2'd3},
      '{1'b1, 4'b1100, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0011, 4'b0110, 1'b0, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0011, 4'b0110, 1'b0, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0110, 1'b0, 2'd2},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0110, 1'b0, 2'd1},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL stall_flush step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_wrpsr_restart();
    // Second WRPSR restarts the count; a flush while pending does not cancel it.
    step_t v [7] = '{
      '{1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b0, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0011, 4'b0011, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1, 2'd0},
      '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1100, 4'b1100, 1'b0, 2'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      checks++;
      if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== {v[i].ef, v[i].ei, v[i].eb, v[i].es}) begin
        errors++;
        $display("FAIL wrpsr_restart step %0d: flags/icc/busy/src got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src, v[i].ef, v[i].ei, v[i].eb, v[i].es);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.EX_modify_cc = 1'b1; bus.EX_alu_flags = 4'b0111;
    bus.EX_wr_psr = 1'b1; bus.EX_wr_psr_icc = 4'b1111;
    tick();
    bus.EX_modify_cc = 1'b0; bus.EX_alu_flags = 4'b0000;
    bus.EX_wr_psr = 1'b0; bus.EX_wr_psr_icc = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== 11'b0000_0000_0_00) begin
      errors++;
      $display("FAIL reset_mid: flags/icc/busy/src got %b/%b/%b/%0d expected 0000/0000/0/0",
               bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src);
    end
    #2 rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if ({bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src} !== 11'b0000_0000_0_00) begin
      errors++;
      $display("FAIL reset_mid_after: flags/icc/busy/src got %b/%b/%b/%0d expected 0000/0000/0/0",
               bus.flags, bus.icc_q, bus.psr_busy, bus.fwd_src);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_wrpsr_override();
    test_stall();
    test_stall_flush_pipe();
    test_wrpsr_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
